// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle instruction sequencer.
//   Walks each instruction through FETCH -> DECODE -> EXEC -> MEM -> WB
//   (skipping the stages an opcode does not need) and drives the memory,
//   ALU and register-bank strobes for each stage.
// Ports:
//   _clock, _reset      : clock, synchronous active-high reset
//   _start              : level, leaves IDLE
//   _mem_ready          : memory finished the current access this cycle
//   _instrucao [31:0]   : instruction word returned by a fetch
//   _pc, _ir [31:0]     : fetch address, latched instruction register
//   _mem_enable, _mem_rw[1:0], _mem_fetch : memory request, 00/10/11, address select
//   _ula_enable, _reg_write               : ALU capture, register write strobes
//   _busy, _halted, _state[2:0]           : status
//   _retired [15:0]                       : completed-instruction counter
module calc_sequencer (
  input  logic        _clock,
  input  logic        _reset,
  input  logic        _start,
  input  logic        _mem_ready,
  input  logic [31:0] _instrucao,
  output logic [31:0] _pc,
  output logic [31:0] _ir,
  output logic        _mem_enable,
  output logic [1:0]  _mem_rw,
  output logic        _mem_fetch,
  output logic        _ula_enable,
  output logic        _reg_write,
  output logic        _busy,
  output logic        _halted,
  output logic [2:0]  _state,
  output logic [15:0] _retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_HALT   = 3'b110
  } state_t;

  state_t      cur_state;
  state_t      next_state;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [15:0] retired_reg;

  logic [3:0]  opcode;
  logic        is_alu;
  logic        is_load;
  logic        is_store;
  logic        is_halt;
  logic        is_nop;
  logic        retire_now;

  // Opcode classification of the latched instruction.
  always_comb begin
    opcode   = ir_reg[31:28];
    is_alu   = (opcode[3] == 1'b0);
    is_load  = (opcode == 4'h8);
    is_store = (opcode == 4'h9);
    is_halt  = (opcode == 4'hF);
    is_nop   = !is_alu && !is_load && !is_store && !is_halt;
  end

  // An instruction completes on a NOP decode, a finished store, or write-back.
  always_comb begin
    retire_now = 1'b0;
    if (cur_state == S_DECODE && is_nop) begin
      retire_now = 1'b1;
    end else if (cur_state == S_MEM && _mem_ready && is_store) begin
      retire_now = 1'b1;
    end else if (cur_state == S_WB) begin
      retire_now = 1'b1;
    end else begin
      retire_now = 1'b0;
    end
  end

  // State register and datapath registers; reset overrides every other update.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      cur_state   <= S_IDLE;
      pc_reg      <= 32'd0;
      ir_reg      <= 32'd0;
      retired_reg <= 16'd0;
    end else begin
      cur_state <= next_state;
      if (cur_state == S_FETCH && _mem_ready) begin
        ir_reg <= _instrucao;
        pc_reg <= pc_reg + 32'd1;
      end
      if (retire_now) begin
        retired_reg <= retired_reg + 16'd1;
      end
    end
  end

  // Next-state logic; the unused encoding 111 recovers to IDLE.
  always_comb begin
    next_state = S_IDLE;
    case (cur_state)
      S_IDLE:   next_state = _start ? S_FETCH : S_IDLE;
      S_FETCH:  next_state = _mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_halt) begin
          next_state = S_HALT;
        end else if (is_nop) begin
          next_state = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC:   next_state = is_alu ? S_WB : S_MEM;
      S_MEM: begin
        if (!_mem_ready) begin
          next_state = S_MEM;
        end else if (is_load) begin
          next_state = S_WB;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state (and the opcode during MEM).
  always_comb begin
    _mem_enable = 1'b0;
    _mem_rw     = 2'b00;
    _mem_fetch  = 1'b0;
    _ula_enable = 1'b0;
    _reg_write  = 1'b0;
    _busy       = 1'b1;
    _halted     = 1'b0;
    case (cur_state)
      S_IDLE:   _busy = 1'b0;
      S_FETCH: begin
        _mem_enable = 1'b1;
        _mem_rw     = 2'b10;
        _mem_fetch  = 1'b1;
      end
      S_DECODE: _busy = 1'b1;
      S_EXEC:   _ula_enable = 1'b1;
      S_MEM: begin
        _mem_enable = 1'b1;
        _mem_rw     = is_store ? 2'b11 : 2'b10;
      end
      S_WB:     _reg_write = 1'b1;
      S_HALT: begin
        _busy   = 1'b0;
        _halted = 1'b1;
      end
      default:  _busy = 1'b1;
    endcase
  end

  assign _state   = cur_state;
  assign _pc      = pc_reg;
  assign _ir      = ir_reg;
  assign _retired = retired_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] instrucao = 32'd0;
  logic [31:0] pc, ir;
  logic        mem_enable, mem_fetch, ula_enable, reg_write, busy, halted;
  logic [1:0]  mem_rw;
  logic [2:0]  state;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  calc_sequencer dut (
    ._clock(clock), ._reset(reset), ._start(start), ._mem_ready(mem_ready),
    ._instrucao(instrucao), ._pc(pc), ._ir(ir), ._mem_enable(mem_enable),
    ._mem_rw(mem_rw), ._mem_fetch(mem_fetch), ._ula_enable(ula_enable),
    ._reg_write(reg_write), ._busy(busy), ._halted(halted), ._state(state),
    ._retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    int          fstall;
    int          mstall;
    int          cycles;
    int          regw;
    int          ula;
    logic [1:0]  rw;
    int          mem_cycles;
    int          ret_inc;
  } vec_t;

  typedef struct {
    int         cycles;
    int         regw;
    int         ula;
    logic [1:0] rw;
    int         mem_cycles;
  } meas_t;

  vec_t tbl[9];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected strobes/status for the state the DUT reports, given the instruction in flight.
  task automatic check_strobes(input logic [31:0] instr);
    logic [7:0] exp;
    logic [1:0] mrw;
    mrw = (instr[31:28] == 4'h9) ? 2'b11 : 2'b10;
    case (state)
      3'b000:  exp = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      3'b001:  exp = {1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      3'b010:  exp = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      3'b011:  exp = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      3'b100:  exp = {1'b1, mrw,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      3'b101:  exp = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      3'b110:  exp = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      default: exp = 8'hFF;
    endcase
    check("strobes", {24'd0, mem_enable, mem_rw, mem_fetch, ula_enable, reg_write, busy, halted},
          {24'd0, exp});
  endtask

  // Runs one instruction from a FETCH cycle until the next FETCH or HALT.
  // Called just after a falling edge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] instr, input int fstall, input int mstall,
                           output meas_t m);
    int fw = 0;
    int mw = 0;
    bit seen_decode = 1'b0;
    bit done = 1'b0;
    m.cycles = 0; m.regw = 0; m.ula = 0; m.rw = 2'b00; m.mem_cycles = 0;
    instrucao = instr;
    for (int k = 0; k < 64; k++) begin
      if (state == 3'b001) begin
        mem_ready = (fw >= fstall); fw++;
      end else if (state == 3'b100) begin
        mem_ready = (mw >= mstall); mw++;
        m.mem_cycles++;
        m.rw = mem_rw;
      end else begin
        mem_ready = 1'b1;  // must be ignored outside FETCH/MEM
      end
      if (state == 3'b010) seen_decode = 1'b1;
      if (reg_write) m.regw++;
      if (ula_enable) m.ula++;
      check_strobes(instr);
      @(negedge clock);
      m.cycles++;
      if (state == 3'b110 || (seen_decode && state == 3'b001)) begin
        done = 1'b1;
        break;
      end
    end
    mem_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: instr 0x%0h did not complete within 64 cycles", instr);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_to_fetch", {29'd0, state}, 32'd1);
  endtask

  initial begin
    meas_t m;
    vec_t  e;
    logic [31:0] exp_pc;
    logic [15:0] exp_ret;

    //        instr         fs ms cyc rw ula rw     memc ret
    tbl[0] = '{32'h10000005, 0, 0, 4,  1, 1, 2'b00, 0, 1};
    tbl[1] = '{32'h7ABCDEF0, 2, 0, 6,  1, 1, 2'b00, 0, 1};
    tbl[2] = '{32'h80000002, 0, 3, 8,  1, 1, 2'b10, 4, 1};
    tbl[3] = '{32'h90000001, 0, 0, 4,  0, 1, 2'b11, 1, 1};
    tbl[4] = '{32'h9000ABCD, 1, 2, 7,  0, 1, 2'b11, 3, 1};
    tbl[5] = '{32'hA0000000, 0, 0, 2,  0, 0, 2'b00, 0, 1};
    tbl[6] = '{32'hE1234567, 1, 0, 3,  0, 0, 2'b00, 0, 1};
    tbl[7] = '{32'h8FFFFFFF, 0, 0, 5,  1, 1, 2'b10, 1, 1};
    tbl[8] = '{32'h00000000, 0, 0, 4,  1, 1, 2'b00, 0, 1};

    // Reset values and staying in IDLE without start.
    do_reset();
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_pc", pc, 32'd0);
    check("reset_ir", ir, 32'd0);
    check("reset_retired", {16'd0, retired}, 32'd0);
    check_strobes(32'd0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    mem_ready = 1'b0;
    check("idle_hold", {29'd0, state}, 32'd0);
    do_start();

    // Table-driven instruction stream through the scoreboard.
    exp_pc = 32'd0;
    exp_ret = 16'd0;
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      run_instr(tbl[i].instr, tbl[i].fstall, tbl[i].mstall, m);
      e = sb.pop_front();
      exp_pc = exp_pc + 32'd1;
      exp_ret = exp_ret + 16'(e.ret_inc);
      check($sformatf("v%0d_cycles", i), m.cycles, e.cycles);
      check($sformatf("v%0d_regw", i), m.regw, e.regw);
      check($sformatf("v%0d_ula", i), m.ula, e.ula);
      check($sformatf("v%0d_rw", i), {30'd0, m.rw}, {30'd0, e.rw});
      check($sformatf("v%0d_memcyc", i), m.mem_cycles, e.mem_cycles);
      check($sformatf("v%0d_ir", i), ir, e.instr);
      check($sformatf("v%0d_pc", i), pc, exp_pc);
      check($sformatf("v%0d_retired", i), {16'd0, retired}, {16'd0, exp_ret});
    end

    // HALT: terminal, no retire, start ignored.
    run_instr(32'hF0000000, 0, 0, m);
    check("halt_cycles", m.cycles, 2);
    check("halt_state", {29'd0, state}, 32'd6);
    check("halt_pc", pc, exp_pc + 32'd1);
    check("halt_retired", {16'd0, retired}, {16'd0, exp_ret});
    start = 1'b1;
    mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    mem_ready = 1'b0;
    check("halt_sticky", {29'd0, state}, 32'd6);
    check_strobes(32'hF0000000);

    // Reset during FETCH with mem_ready high on the same edge.
    do_reset();
    do_start();
    run_instr(32'h10000005, 0, 0, m);
    check("pre_reset_pc", pc, 32'd1);
    reset = 1'b1;
    mem_ready = 1'b1;
    instrucao = 32'h12345678;
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
    check("midreset_state", {29'd0, state}, 32'd0);
    check("midreset_pc", pc, 32'd0);
    check("midreset_ir", ir, 32'd0);
    check("midreset_retired", {16'd0, retired}, 32'd0);
    check("midreset_mem_en", {31'd0, mem_enable}, 32'd0);

    // Retired counter wrap: preload 0xFFFF while idle, then retire one NOP.
    force dut.retired_reg = 16'hFFFF;
    repeat (2) @(negedge clock);
    release dut.retired_reg;
    @(negedge clock);
    check("preload_retired", {16'd0, retired}, 32'h0000FFFF);
    do_start();
    run_instr(32'hB0000000, 0, 0, m);
    check("wrap_retired", {16'd0, retired}, 32'd0);
    check("wrap_pc", pc, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
